// File: rtl/matrix_operand_loader_pkg.sv
// Shared constants and state encoding for the matrix operand loader.
// Frames carry A then B, each stored row-major.
package matrix_operand_loader_pkg;
  localparam int ELEM_W    = 3;
  localparam int DIM       = 4;
  localparam int NELEM     = DIM * DIM;
  localparam int FRAME_LEN = 2 * NELEM;
  localparam int K_W       = $clog2(FRAME_LEN);
  localparam int IDX_W     = $clog2(NELEM);
  localparam int RC_W      = $clog2(DIM);
  localparam int FLAT_W    = NELEM * ELEM_W;
  localparam int BIT_W     = $clog2(FLAT_W);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;
endpackage

// File: rtl/matrix_operand_loader_beat_decoder.sv
// Maps a beat index within a frame to its target matrix, row and column.
// The first NELEM beats go to A, the remaining NELEM beats go to B.
module beat_decoder
  import matrix_operand_loader_pkg::*;
(
  input  logic [K_W-1:0]  k_i,
  output logic            sel_b_o,
  output logic [RC_W-1:0] row_o,
  output logic [RC_W-1:0] col_o
);
  logic [IDX_W-1:0] idx;

  assign sel_b_o = (k_i >= K_W'(NELEM));
  assign idx     = sel_b_o ? IDX_W'(k_i - K_W'(NELEM)) : IDX_W'(k_i);
  assign row_o   = RC_W'(idx / IDX_W'(DIM));
  assign col_o   = RC_W'(idx % IDX_W'(DIM));
endmodule

// File: rtl/matrix_operand_loader.sv
// Assembles serial 3-bit elements into operand matrices A and B and holds them
// on flat buses until the multiplier accepts the frame.
module matrix_operand_loader
  import matrix_operand_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_last,
  output logic [FLAT_W-1:0] a_flat,
  output logic [FLAT_W-1:0] b_flat,
  output logic              mats_valid,
  input  logic              mats_ready,
  output logic              frame_err,
  output logic [7:0]        frame_cnt,
  output state_e            dbg_state
);
  // Handshake: a beat transfers on a rising edge with in_valid && in_ready,
  // a frame transfers on a rising edge with mats_valid && mats_ready.
  localparam logic [K_W-1:0] LAST_K = K_W'(FRAME_LEN - 1);

  state_e            state_q;
  logic [K_W-1:0]    k_q;
  logic [FLAT_W-1:0] a_q;
  logic [FLAT_W-1:0] b_q;
  logic              frame_err_q;
  logic [7:0]        frame_cnt_q;

  logic              dec_sel_b;
  logic [RC_W-1:0]   dec_row;
  logic [RC_W-1:0]   dec_col;
  logic [IDX_W-1:0]  elem_idx;
  logic [BIT_W-1:0]  bit_base;
  logic              accept;

  beat_decoder u_beat_decoder (
    .k_i     (k_q),
    .sel_b_o (dec_sel_b),
    .row_o   (dec_row),
    .col_o   (dec_col)
  );

  assign elem_idx = IDX_W'(int'(dec_row) * DIM + int'(dec_col));
  assign bit_base = BIT_W'(elem_idx) * BIT_W'(ELEM_W);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            if (dec_sel_b) b_q[bit_base +: ELEM_W] <= in_data;
            else           a_q[bit_base +: ELEM_W] <= in_data;
            if (k_q == LAST_K) begin
              k_q <= '0;
              if (in_last) begin
                state_q <= ST_HOLD;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= ST_FLUSH;
              end
            end else if (in_last) begin
              // Short frame: restart at A[0][0]; stale elements are simply overwritten later.
              frame_err_q <= 1'b1;
              k_q         <= '0;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          if (accept && in_last) state_q <= ST_LOAD;
        end
        ST_HOLD: begin
          if (mats_ready) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
            state_q     <= ST_LOAD;
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign in_ready   = (state_q != ST_HOLD);
  assign mats_valid = (state_q == ST_HOLD);
  assign a_flat     = a_q;
  assign b_flat     = b_q;
  assign frame_err  = frame_err_q;
  assign frame_cnt  = frame_cnt_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_matrix_operand_loader.sv
// Bench for matrix_operand_loader: directed framing cases, async reset and a
// long randomised run checked against an expected-frame queue.
module tb_matrix_operand_loader;
  import matrix_operand_loader_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [ELEM_W-1:0] in_data;
  logic              in_last;
  logic [FLAT_W-1:0] a_flat;
  logic [FLAT_W-1:0] b_flat;
  logic              mats_valid;
  logic              mats_ready;
  logic              frame_err;
  logic [7:0]        frame_cnt;
  state_e            dbg_state;

  matrix_operand_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .a_flat     (a_flat),
    .b_flat     (b_flat),
    .mats_valid (mats_valid),
    .mats_ready (mats_ready),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  int               checks = 0;
  int               errors = 0;
  logic [95:0]      exp_q[$];
  logic [95:0]      mon_exp;
  logic [7:0]       exp_cnt = 8'd0;
  int               ready_mode = 1;
  bit               gaps_on = 1'b0;
  int               err_seen = 0;
  int               hand_cnt = 0;
  int               valid_cycles = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Consumer side: choose mats_ready for the coming edge, then score any handoff it causes.
  always @(negedge clk) begin
    case (ready_mode)
      0:       mats_ready = 1'b0;
      1:       mats_ready = 1'b1;
      default: mats_ready = ($urandom_range(0, 3) != 0);
    endcase
    if (!rst_n) begin
      exp_cnt = 8'd0;
    end else begin
      if (frame_err)  err_seen++;
      if (mats_valid) valid_cycles++;
      if (mats_valid && mats_ready) begin
        hand_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_handoff", 96'd1, 96'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("handoff_data", {a_flat, b_flat}, mon_exp);
        end
        check("frame_cnt_at_handoff", 96'(frame_cnt), 96'(exp_cnt));
        exp_cnt = exp_cnt + 8'd1;
      end
    end
  end

  task automatic send_beat(input logic [ELEM_W-1:0] d, input logic last);
    int n;
    if (gaps_on && $urandom_range(0, 2) == 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 96'd0, 96'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Full frames (len >= 32) push their expected {A,B} image before the beats go out.
  task automatic send_frame(input int len, input int last_pos, input bit push, input bit rnd);
    logic [ELEM_W-1:0] d[40];
    logic [95:0]       e;
    e = '0;
    for (int k = 0; k < len; k++) d[k] = rnd ? 3'($urandom_range(0, 7)) : 3'(k % 8);
    if (len >= 32) begin
      for (int k = 0; k < 16; k++) e[48 + k*3 +: 3] = d[k];
      for (int k = 16; k < 32; k++) e[(k-16)*3 +: 3] = d[k];
    end
    if (push) exp_q.push_back(e);
    for (int k = 0; k < len; k++) send_beat(d[k], k == last_pos);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_timeout", 96'(exp_q.size()), 96'd0);
  endtask

  initial begin
    #800000;
    errors++;
    $display("FAIL watchdog expired got running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int e0, h0, v0;
    logic [95:0] snap;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    #1;
    check("rst_a_flat",     96'(a_flat),     96'd0);
    check("rst_b_flat",     96'(b_flat),     96'd0);
    check("rst_mats_valid", 96'(mats_valid), 96'd0);
    check("rst_frame_err",  96'(frame_err),  96'd0);
    check("rst_frame_cnt",  96'(frame_cnt),  96'd0);
    check("rst_in_ready",   96'(in_ready),   96'd1);
    check("rst_state",      96'(dbg_state),  96'(ST_LOAD));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: counting frame, consumer always ready
    ready_mode = 1;
    v0 = valid_cycles;
    send_frame(32, 31, 1'b1, 1'b0);
    check("t1_mats_valid", 96'(mats_valid), 96'd1);
    check("t1_in_ready_hold", 96'(in_ready), 96'd0);
    check("t1_a00", 96'(a_flat[2:0]), 96'd0);
    check("t1_b33", 96'(b_flat[47:45]), 96'd7);
    @(posedge clk); #1;
    check("t1_valid_drop", 96'(mats_valid), 96'd0);
    check("t1_frame_cnt", 96'(frame_cnt), 96'd1);
    check("t1_in_ready", 96'(in_ready), 96'd1);
    check("t1_valid_cycles", 96'(valid_cycles - v0), 96'd1);

    // 2: consumer stalls for 10 cycles
    ready_mode = 0;
    send_frame(32, 31, 1'b1, 1'b1);
    snap = {a_flat, b_flat};
    for (int i = 0; i < 10; i++) begin
      check("t2_mats_valid", 96'(mats_valid), 96'd1);
      check("t2_in_ready",   96'(in_ready),   96'd0);
      check("t2_stable",     {a_flat, b_flat}, snap);
      @(posedge clk); #1;
    end
    ready_mode = 1;
    @(posedge clk); #1;
    check("t2_in_ready_after", 96'(in_ready), 96'd1);
    check("t2_valid_after",    96'(mats_valid), 96'd0);
    check("t2_frame_cnt",      96'(frame_cnt), 96'd2);

    // 3: short frame then a full frame
    e0 = err_seen; h0 = hand_cnt;
    send_frame(6, 5, 1'b0, 1'b1);
    send_frame(32, 31, 1'b1, 1'b1);
    wait_drain();
    check("t3_err_pulses", 96'(err_seen - e0), 96'd1);
    check("t3_handoffs",   96'(hand_cnt - h0), 96'd1);
    check("t3_frame_cnt",  96'(frame_cnt), 96'd3);

    // 4: long frame is flushed, then a full frame
    e0 = err_seen; h0 = hand_cnt;
    send_frame(36, 35, 1'b0, 1'b1);
    repeat (3) @(posedge clk); #1;
    check("t4_err_pulses", 96'(err_seen - e0), 96'd1);
    check("t4_no_handoff", 96'(hand_cnt - h0), 96'd0);
    check("t4_no_valid",   96'(mats_valid), 96'd0);
    send_frame(32, 31, 1'b1, 1'b1);
    wait_drain();
    check("t4_handoffs",   96'(hand_cnt - h0), 96'd1);
    check("t4_frame_cnt",  96'(frame_cnt), 96'd4);

    // 5: asynchronous reset mid-frame
    send_frame(21, 99, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_a_flat",     96'(a_flat),     96'd0);
    check("t5_b_flat",     96'(b_flat),     96'd0);
    check("t5_mats_valid", 96'(mats_valid), 96'd0);
    check("t5_frame_cnt",  96'(frame_cnt),  96'd0);
    check("t5_frame_err",  96'(frame_err),  96'd0);
    check("t5_in_ready",   96'(in_ready),   96'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // 6: random gaps and backpressure over 300 frames (the first also covers recovery from reset)
    h0 = hand_cnt;
    gaps_on    = 1'b1;
    ready_mode = 2;
    for (int f = 0; f < 300; f++) send_frame(32, 31, 1'b1, 1'b1);
    wait_drain();
    check("t6_handoffs",  96'(hand_cnt - h0), 96'd300);
    check("t6_frame_cnt", 96'(frame_cnt), 96'd44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
